// File: rtl/hazard_pkg.sv
// Shared hazard-control types: FSM state encoding, the x0 register index,
// and the bundle of stall/flush bits driven into the pipeline registers.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } pipe_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping, so a long
// performance run never reports a misleadingly small count.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/stall_flush_unit.sv
// Stall/flush generator for the 5-stage RV32I pipeline: load-use interlock,
// branch flush and data-memory wait freeze with a sticky timeout error.
module stall_flush_unit
    import hazard_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       RD_E,
    input  logic             MemReadE,
    input  logic             PCSrcE,
    input  logic             DMemReq_M,
    input  logic             DMemReady_M,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushEvents
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    hz_state_t         state, state_next;
    logic [WCNT_W-1:0] wcnt, wcnt_next;
    logic              lu, ms, frz;
    pipe_ctrl_t        ctrl;

    assign lu  = MemReadE && (RD_E != REG_ZERO) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));
    assign ms  = DMemReq_M && !DMemReady_M;
    // Freeze starts in the same cycle the miss appears and drops in the ready cycle.
    assign frz = ms || ((state == MEM_WAIT) && !DMemReady_M) || (state == ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            wcnt  <= '0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
        end
    end

    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        case (state)
            RUN: begin
                if (ms) begin
                    state_next = MEM_WAIT;
                    wcnt_next  = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (DMemReady_M) begin
                    state_next = RUN;
                end else if (wcnt == WCNT_LAST) begin
                    state_next = ERR;
                end else begin
                    wcnt_next = wcnt + 1'b1;
                end
            end
            ERR:     state_next = ERR;
            default: state_next = RUN;
        endcase
    end

    // Freeze outranks branch; branch outranks load-use since Decode is wrong-path.
    always_comb begin
        ctrl = '0;
        if (rst) begin
            if (frz) begin
                ctrl.stall_f = 1'b1;
                ctrl.stall_d = 1'b1;
                ctrl.stall_e = 1'b1;
                ctrl.stall_m = 1'b1;
                ctrl.flush_w = 1'b1;
            end else if (PCSrcE) begin
                ctrl.flush_d = 1'b1;
                ctrl.flush_e = 1'b1;
            end else if (lu) begin
                ctrl.stall_f = 1'b1;
                ctrl.stall_d = 1'b1;
                ctrl.flush_e = 1'b1;
            end
        end
    end

    assign StallF     = ctrl.stall_f;
    assign StallD     = ctrl.stall_d;
    assign StallE     = ctrl.stall_e;
    assign StallM     = ctrl.stall_m;
    assign FlushD     = ctrl.flush_d;
    assign FlushE     = ctrl.flush_e;
    assign FlushW     = ctrl.flush_w;
    assign MemTimeout = rst && (state == ERR);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ctrl.stall_f),
        .count (StallCycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (rst && PCSrcE && !frz),
        .count (FlushEvents)
    );

endmodule

// File: tb/tb_stall_flush_unit.sv
// Self-checking bench for stall_flush_unit: directed scenarios plus random
// traffic compared against a behavioural hazard model.
module tb_stall_flush_unit;

    localparam int CW = 4;
    localparam int MT = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk, rst;
    logic [4:0]    Rs1_D, Rs2_D, RD_E;
    logic          MemReadE, PCSrcE, DMemReq_M, DMemReady_M;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
    logic [CW-1:0] StallCycles, FlushEvents;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit m_err, m_pend;
    int m_wait, m_stall, m_flush;

    stall_flush_unit #(.CNT_W(CW), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .RD_E(RD_E),
        .MemReadE(MemReadE), .PCSrcE(PCSrcE), .DMemReq_M(DMemReq_M),
        .DMemReady_M(DMemReady_M), .StallF(StallF), .StallD(StallD),
        .StallE(StallE), .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE),
        .FlushW(FlushW), .MemTimeout(MemTimeout), .StallCycles(StallCycles),
        .FlushEvents(FlushEvents)
    );

    wire [15:0] obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                       MemTimeout, StallCycles, FlushEvents};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_frz();
        return m_err || (DMemReq_M && !DMemReady_M) || (m_pend && !DMemReady_M);
    endfunction

    function automatic logic [6:0] exp_ctrl();
        bit lu;
        lu = MemReadE && (RD_E != 0) && (RD_E == Rs1_D || RD_E == Rs2_D);
        if (!rst)          return 7'b0;
        if (m_frz())       return 7'b1111_001;
        if (PCSrcE)        return 7'b0000_110;
        if (lu)            return 7'b1100_010;
        return 7'b0;
    endfunction

    function automatic logic [15:0] exp_obs();
        logic [3:0] s, f;
        s = m_stall[3:0];
        f = m_flush[3:0];
        return {exp_ctrl(), rst && m_err, s, f};
    endfunction

    task automatic clear_inputs();
        Rs1_D = 0; Rs2_D = 0; RD_E = 0;
        MemReadE = 0; PCSrcE = 0; DMemReq_M = 0; DMemReady_M = 0;
    endtask

    // Advance one clock, updating the model from the pre-edge inputs.
    task automatic tick();
        logic [6:0] e;
        bit f;
        e = exp_ctrl();
        f = m_frz();
        @(posedge clk);
        if (rst) begin
            if (e[6] && m_stall < SAT) m_stall++;
            if (PCSrcE && !f && m_flush < SAT) m_flush++;
            if (!m_err) begin
                if (m_pend) begin
                    if (DMemReady_M) m_pend = 0;
                    else if (m_wait == MT - 1) begin m_err = 1; m_pend = 0; end
                    else m_wait++;
                end else if (DMemReq_M && !DMemReady_M) begin
                    m_pend = 1;
                    m_wait = 1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m_err = 0; m_pend = 0; m_wait = 0; m_stall = 0; m_flush = 0;
        clear_inputs();
        #1;
        checks++;
        if (obs !== 16'h0) begin
            errors++; $display("FAIL reset_idle act=%h exp=%h", obs, 16'h0);
        end
        DMemReq_M = 1; PCSrcE = 1; MemReadE = 1; RD_E = 3; Rs1_D = 3;
        #1;
        checks++;
        if (obs !== 16'h0) begin
            errors++; $display("FAIL reset_gated act=%h exp=%h", obs, 16'h0);
        end
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        test_reset();
        MemReadE = 1; RD_E = 5; Rs1_D = 5;
        @(negedge clk);
        checks++;
        if (obs !== exp_obs() || obs[15:9] !== 7'b1100_010) begin
            errors++; $display("FAIL load_use act=%h exp=%h", obs, exp_obs());
        end
        tick();
        MemReadE = 0;
        @(negedge clk);
        checks++;
        if (obs !== exp_obs() || StallCycles !== 4'd1) begin
            errors++; $display("FAIL load_use_count act=%h exp=%h", obs, exp_obs());
        end
        MemReadE = 1; RD_E = 0; Rs1_D = 0;
        @(negedge clk);
        checks++;
        if (obs[15:9] !== 7'b0) begin
            errors++; $display("FAIL load_use_x0 act=%b exp=%b", obs[15:9], 7'b0);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_branch_lu();
        test_reset();
        MemReadE = 1; RD_E = 5; Rs2_D = 5; PCSrcE = 1;
        @(negedge clk);
        checks++;
        if (obs !== exp_obs() || obs[15:9] !== 7'b0000_110) begin
            errors++; $display("FAIL branch_lu act=%h exp=%h", obs, exp_obs());
        end
        tick();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (FlushEvents !== 4'd1 || StallCycles !== 4'd0) begin
            errors++; $display("FAIL branch_count act=%0d/%0d exp=1/0", FlushEvents, StallCycles);
        end
    endtask

    task automatic test_mem_wait();
        test_reset();
        DMemReq_M = 1; DMemReady_M = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_obs() || obs[15:9] !== 7'b1111_001) begin
                errors++; $display("FAIL mem_wait_c%0d act=%h exp=%h", i, obs, exp_obs());
            end
            tick();
        end
        DMemReady_M = 1;
        @(negedge clk);
        checks++;
        if (obs !== exp_obs() || obs[15:9] !== 7'b0) begin
            errors++; $display("FAIL mem_release act=%h exp=%h", obs, exp_obs());
        end
        tick();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (obs !== exp_obs() || StallCycles !== 4'd3) begin
            errors++; $display("FAIL mem_after act=%h exp=%h", obs, exp_obs());
        end
        DMemReq_M = 1;
        @(negedge clk);
        checks++;
        if (StallF !== 1'b1) begin
            errors++; $display("FAIL mem_rearm act=%b exp=1", StallF);
        end
        tick();
        DMemReady_M = 1;
        tick();
        clear_inputs();
    endtask

    task automatic test_freeze_branch();
        test_reset();
        PCSrcE = 1; DMemReq_M = 1; DMemReady_M = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_obs() || FlushD !== 1'b0 || FlushE !== 1'b0) begin
                errors++; $display("FAIL freeze_branch_c%0d act=%h exp=%h", i, obs, exp_obs());
            end
            tick();
        end
        DMemReady_M = 1;
        @(negedge clk);
        checks++;
        if (obs !== exp_obs() || obs[15:9] !== 7'b0000_110) begin
            errors++; $display("FAIL freeze_release act=%h exp=%h", obs, exp_obs());
        end
        tick();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (FlushEvents !== 4'd1) begin
            errors++; $display("FAIL freeze_flush_cnt act=%0d exp=1", FlushEvents);
        end
    endtask

    task automatic test_timeout();
        test_reset();
        DMemReq_M = 1; DMemReady_M = 0;
        for (int i = 0; i < MT; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_obs() || MemTimeout !== 1'b0) begin
                errors++; $display("FAIL timeout_pre_c%0d act=%h exp=%h", i, obs, exp_obs());
            end
            tick();
        end
        DMemReq_M = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_obs() || MemTimeout !== 1'b1 || StallM !== 1'b1) begin
                errors++; $display("FAIL timeout_err_c%0d act=%h exp=%h", i, obs, exp_obs());
            end
            tick();
        end
        rst = 1'b0;
        m_err = 0; m_pend = 0; m_stall = 0; m_flush = 0;
        #1;
        checks++;
        if (obs !== 16'h0) begin
            errors++; $display("FAIL timeout_reset act=%h exp=%h", obs, 16'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (obs !== 16'h0) begin
            errors++; $display("FAIL timeout_run act=%h exp=%h", obs, 16'h0);
        end
    endtask

    task automatic test_saturation();
        test_reset();
        MemReadE = 1; RD_E = 9; Rs2_D = 9;
        for (int i = 0; i < 20; i++) tick();
        @(negedge clk);
        checks++;
        if (StallCycles !== 4'd15 || obs !== exp_obs()) begin
            errors++; $display("FAIL saturation act=%0d exp=15", StallCycles);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        test_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0 || (m_err && $urandom_range(0, 3) == 0)) begin
                test_reset();
            end
            Rs1_D       = 5'($urandom_range(0, 7));
            Rs2_D       = 5'($urandom_range(0, 7));
            RD_E        = 5'($urandom_range(0, 7));
            MemReadE    = ($urandom_range(0, 2) == 0);
            PCSrcE      = ($urandom_range(0, 3) == 0);
            DMemReq_M   = ($urandom_range(0, 2) == 0);
            DMemReady_M = ($urandom_range(0, 1) == 0);
            @(negedge clk);
            checks++;
            if (obs !== exp_obs()) begin
                errors++; $display("FAIL random_c%0d act=%h exp=%h", i, obs, exp_obs());
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch_lu();
        test_mem_wait();
        test_freeze_branch();
        test_timeout();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stall_flush_unit.md
Name: stall_flush_unit

Overview:
- Producer-side counterpart to the pipeline's operand-forwarding logic: it resolves the hazards forwarding cannot, by generating the stall and flush controls for the 5-stage RV32I pipeline.
- Handles three cases: load-use interlock (Decode vs Execute), taken-branch/jump flush, and multi-cycle data-memory wait with timeout detection.
- Sits beside the forwarding unit and drives the enable and clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- CNT_W, 16, width of the performance counters.
- MEM_TIMEOUT, 64, maximum consecutive MEM_WAIT cycles before a timeout error (must be >= 2).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- Rs1_D  input  5  rs1 index of the instruction in Decode.
- Rs2_D  input  5  rs2 index of the instruction in Decode.
- RD_E  input  5  destination index of the instruction in Execute.
- MemReadE  input  1  instruction in Execute is a load.
- PCSrcE  input  1  branch taken or jump resolved in Execute.
- DMemReq_M  input  1  Memory stage is issuing a data-memory access.
- DMemReady_M  input  1  data memory completes the access this cycle.
- StallF  output  1  hold PC.
- StallD  output  1  hold IF/ID.
- StallE  output  1  hold ID/EX.
- StallM  output  1  hold EX/MEM.
- FlushD  output  1  clear IF/ID to a bubble.
- FlushE  output  1  clear ID/EX to a bubble.
- FlushW  output  1  clear MEM/WB to a bubble.
- MemTimeout  output  1  sticky memory-timeout error.
- StallCycles  output  CNT_W  count of cycles with StallF=1, saturating.
- FlushEvents  output  CNT_W  count of cycles with FlushD or FlushE from a branch, saturating.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-low.
- While rst=0: all outputs are 0, the FSM is in RUN, the wait counter and both performance counters are 0, and MemTimeout is 0.
- Internal terms, all combinational:
  - LU = MemReadE & (RD_E!=0) & ((RD_E==Rs1_D) | (RD_E==Rs2_D)).
  - MS = DMemReq_M & ~DMemReady_M.
- FSM states: RUN, MEM_WAIT, ERR, with a wait counter WCNT.
  - RUN: if MS, go to MEM_WAIT next cycle and set WCNT=1.
  - MEM_WAIT: if DMemReady_M, go to RUN. Else if WCNT==MEM_TIMEOUT-1, go to ERR. Else WCNT++.
  - ERR: absorbing until reset. MemTimeout=1 from the first ERR cycle.
- Freeze condition: FRZ = MS | (state==MEM_WAIT & ~DMemReady_M) | (state==ERR).
- FRZ=1 outputs: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. This holds in the same cycle MS first rises, with zero latency.
- FRZ=0, PCSrcE=1: FlushD=1, FlushE=1, all stalls 0. The branch takes priority over LU because the Decode instruction is wrong-path.
- FRZ=0, PCSrcE=0, LU=1: StallF=1, StallD=1, FlushE=1, all else 0. This lasts exactly one cycle; the load moves on to M and LU drops.
- Otherwise all controls are 0.
- A branch or load-use occurring during a freeze is suppressed, not lost. Execute is held, so PCSrcE or LU is still asserted and is acted on in the first unfrozen cycle.
- In the cycle DMemReady_M=1 in MEM_WAIT, the freeze releases combinationally.
- All stall and flush outputs are combinational from the inputs and the registered state. There are no registered control outputs.
- Counters:
  - StallCycles increments on every clk where StallF=1.
  - FlushEvents increments where PCSrcE & ~FRZ.
  - Both hold at all-ones.
- Reset asserted mid-MEM_WAIT or in ERR returns to RUN immediately, asynchronously.

Decomposition:
- Package hazard_pkg:
  - typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} hz_state_t.
  - Constant REG_ZERO = 5'd0.
  - Struct pipe_ctrl_t grouping the Stall and Flush bits, for reuse by the pipeline top.
- One sub-module: sat_counter (parameter W; inputs clk, rst, inc; output count). It is instantiated twice.

Test Plan:
- Load-use: MemReadE=1, RD_E=5, Rs1_D=5, others 0 -> StallF=StallD=FlushE=1 for one cycle, StallCycles=1. Same case with RD_E=0 -> all controls 0.
- Branch plus load-use: PCSrcE=1 with the above LU -> FlushD=FlushE=1, StallF=0, FlushEvents=1.
- Memory wait: DMemReq_M=1, DMemReady_M=0 for 3 cycles, then ready -> StallF..M=1 and FlushW=1 for 3 cycles, all 0 on the ready cycle, state returns to RUN, StallCycles=3.
- Freeze with pending branch: PCSrcE=1 throughout a 2-cycle wait -> no flush during the freeze, FlushD=FlushE=1 on the release cycle, FlushEvents=1.
- Timeout: MEM_TIMEOUT=4, request never ready -> MemTimeout=1 after cycle 4 and stays, the freeze persists, and rst=0 clears all.
- Saturation: CNT_W=4, hold LU for 20 cycles -> StallCycles=15 and holds.
